// File: rtl/branch_cond_if.sv
// branch_cond_if
//   Handshake/bus bundle between the datapath/control unit and
//   branch_cond_unit.
//   master : drives bus, op_a_in, con_in, ir_cond, two_op, con_ack;
//            receives con_out, con_valid, busy, eval_count, taken_count.
//   slave  : the branch-condition unit, with the opposite directions.
interface branch_cond_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     bus;
  logic                 op_a_in;
  logic                 con_in;
  logic [2:0]           ir_cond;
  logic                 two_op;
  logic                 con_ack;
  logic                 con_out;
  logic                 con_valid;
  logic                 busy;
  logic [CNT_WIDTH-1:0] eval_count;
  logic [CNT_WIDTH-1:0] taken_count;

  modport master (
    output bus, op_a_in, con_in, ir_cond, two_op, con_ack,
    input  con_out, con_valid, busy, eval_count, taken_count
  );

  modport slave (
    input  bus, op_a_in, con_in, ir_cond, two_op, con_ack,
    output con_out, con_valid, busy, eval_count, taken_count
  );
endinterface

// File: rtl/branch_cond_unit.sv
// branch_cond_unit
//   Evaluates one of eight condition codes, either on operand B against
//   zero or as a signed A-versus-B compare, registers the decision and
//   hands it to the control unit with a valid/acknowledge handshake.
//   Saturating counters record completed and taken evaluations.
// Ports:
//   clk      system clock, rising edge
//   clear_n  asynchronous active-low reset
//   bif      branch_cond_if.slave (bus, op_a_in, con_in, ir_cond, two_op,
//            con_ack in; con_out, con_valid, busy, eval_count,
//            taken_count out)
module branch_cond_unit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          clear_n,
  branch_cond_if.slave  bif
);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] op_a;
  logic signed [WIDTH-1:0] op_b;
  logic [2:0]              cond;
  logic                    two;
  logic                    con_out_r;
  logic                    con_valid_r;
  logic                    busy_r;
  logic [CNT_WIDTH-1:0]    eval_cnt;
  logic [CNT_WIDTH-1:0]    taken_cnt;

  logic signed [WIDTH-1:0] cmp_x;
  logic signed [WIDTH-1:0] cmp_y;
  logic signed [WIDTH:0]   cmp_diff;
  logic                    cmp_lt;
  logic                    cmp_eq;
  logic                    decision;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic decode_cond(input logic [2:0] code, input logic lt,
                                       input logic eq);
    case (code)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b010:  return !lt;
      3'b011:  return lt;
      3'b100:  return !lt && !eq;
      3'b101:  return lt || eq;
      3'b110:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Compare stage: one extra bit on the subtraction keeps lt correct when
  // A - B overflows WIDTH bits. With Y=0, lt reduces to B's sign bit.
  always_comb begin
    cmp_x    = two ? op_a : op_b;
    cmp_y    = two ? op_b : '0;
    cmp_diff = {cmp_x[WIDTH-1], cmp_x} - {cmp_y[WIDTH-1], cmp_y};
    cmp_lt   = cmp_diff[WIDTH];
    cmp_eq   = (cmp_x == cmp_y);
    decision = decode_cond(cond, cmp_lt, cmp_eq);
  end

  // Control and result registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      cond        <= 3'b000;
      two         <= 1'b0;
      con_out_r   <= 1'b0;
      con_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      eval_cnt    <= '0;
      taken_cnt   <= '0;
    end else begin
      // A loads in every state; EVAL reads the value held before this edge.
      if (bif.op_a_in) op_a <= bif.bus;
      case (state)
        IDLE: begin
          if (bif.con_in) begin
            op_b   <= bif.bus;
            cond   <= bif.ir_cond;
            two    <= bif.two_op;
            busy_r <= 1'b1;
            state  <= EVAL;
          end
        end
        EVAL: begin
          con_out_r   <= decision;
          con_valid_r <= 1'b1;
          busy_r      <= 1'b0;
          eval_cnt    <= sat_inc(eval_cnt);
          if (decision) taken_cnt <= sat_inc(taken_cnt);
          state       <= HOLD;
        end
        HOLD: begin
          // A new strobe implicitly consumes the pending result.
          if (bif.con_in) begin
            op_b        <= bif.bus;
            cond        <= bif.ir_cond;
            two         <= bif.two_op;
            busy_r      <= 1'b1;
            con_valid_r <= 1'b0;
            state       <= EVAL;
          end else if (bif.con_ack) begin
            con_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bif.con_out     = con_out_r;
  assign bif.con_valid   = con_valid_r;
  assign bif.busy        = busy_r;
  assign bif.eval_count  = eval_cnt;
  assign bif.taken_count = taken_cnt;

endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  branch_cond_if #(.WIDTH(32), .CNT_WIDTH(16)) bif ();
  branch_cond_if #(.WIDTH(32), .CNT_WIDTH(2))  sif ();

  // The narrow-counter instance sees exactly the same stimulus.
  assign sif.bus     = bif.bus;
  assign sif.op_a_in = bif.op_a_in;
  assign sif.con_in  = bif.con_in;
  assign sif.ir_cond = bif.ir_cond;
  assign sif.two_op  = bif.two_op;
  assign sif.con_ack = bif.con_ack;

  branch_cond_unit #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .clear_n(clear_n), .bif(bif)
  );

  branch_cond_unit #(.WIDTH(32), .CNT_WIDTH(2)) u_dut_small (
    .clk(clk), .clear_n(clear_n), .bif(sif)
  );

  int pass_cnt = 0;
  int total    = 0;
  int m_eval   = 0;
  int m_taken  = 0;
  int s_eval   = 0;
  int s_taken  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed integer comparison on 64-bit values.
  function automatic bit model(input bit [2:0] code, input bit two,
                               input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    if (two) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'($signed(b));
      y = 0;
    end
    case (code)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd2: return x >= y;
      3'd3: return x < y;
      3'd4: return x > y;
      3'd5: return x <= y;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive operands and the strobe; returns one cycle into EVAL.
  task automatic launch(input bit [2:0] code, input bit two,
                        input logic [31:0] a, input logic [31:0] b);
    if (two) begin
      bif.bus = a; bif.op_a_in = 1'b1; bif.con_in = 1'b0;
      step();
      bif.op_a_in = 1'b0;
    end
    bif.bus = b; bif.con_in = 1'b1; bif.ir_cond = code; bif.two_op = two;
    step();
    bif.con_in = 1'b0;
    bif.bus = $urandom;
    check("eval_busy", bif.busy, 1'b1);
    check("eval_valid", bif.con_valid, 1'b0);
  endtask

  // After the EVAL->HOLD edge: result, handshake flags and counters.
  task automatic post_check(input bit exp);
    if (m_eval < 65535) m_eval++;
    if (exp && m_taken < 65535) m_taken++;
    if (s_eval < 3) s_eval++;
    if (exp && s_taken < 3) s_taken++;
    check("con_out", bif.con_out, exp);
    check("con_valid", bif.con_valid, 1'b1);
    check("busy_done", bif.busy, 1'b0);
    check("eval_count", bif.eval_count, m_eval);
    check("taken_count", bif.taken_count, m_taken);
    check("small_eval", sif.eval_count, s_eval);
    check("small_taken", sif.taken_count, s_taken);
  endtask

  task automatic issue(input bit [2:0] code, input bit two,
                       input logic [31:0] a, input logic [31:0] b);
    launch(code, two, a, b);
    step();
    post_check(model(code, two, a, b));
  endtask

  task automatic ack();
    bif.con_ack = 1'b1;
    step();
    bif.con_ack = 1'b0;
    check("ack_valid", bif.con_valid, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit [7:0] tbl_neg;
    bit [7:0] tbl_pos;
    logic held;
    logic [31:0] ra, rb;
    bit [2:0] rc;
    bit rt;

    tbl_neg = 8'b0110_1010;  // bit i = expected for code i, bus = 0x80000000
    tbl_pos = 8'b0101_0110;  // bit i = expected for code i, bus = 5
    bif.bus = '0; bif.op_a_in = 1'b0; bif.con_in = 1'b0;
    bif.ir_cond = 3'b000; bif.two_op = 1'b0; bif.con_ack = 1'b0;

    step(); step();
    check("rst_con_out", bif.con_out, 1'b0);
    check("rst_valid", bif.con_valid, 1'b0);
    check("rst_busy", bif.busy, 1'b0);
    check("rst_eval", bif.eval_count, 16'd0);
    check("rst_taken", bif.taken_count, 16'd0);
    clear_n = 1'b1;
    step();

    // First evaluation: B=0 eq zero
    issue(3'b000, 1'b0, 32'h0, 32'h0);
    ack();

    // Single-operand sweeps
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 1'b0, 32'h0, 32'h8000_0000);
      check("sweep_neg", bif.con_out, tbl_neg[i]);
      ack();
    end
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 1'b0, 32'h0, 32'd5);
      check("sweep_pos", bif.con_out, tbl_pos[i]);
      ack();
    end

    // Overflow-safe two-operand compare
    issue(3'b100, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    check("gt_ovf", bif.con_out, 1'b1);
    ack();
    issue(3'b100, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
    check("gt_ovf_swap", bif.con_out, 1'b0);
    ack();

    // op_a_in and con_in on the same edge: A == B
    bif.bus = 32'h1234_5678; bif.op_a_in = 1'b1; bif.con_in = 1'b1;
    bif.ir_cond = 3'b000; bif.two_op = 1'b1;
    step();
    bif.op_a_in = 1'b0; bif.con_in = 1'b0; bif.bus = 32'h0;
    step();
    post_check(1'b1);
    ack();

    // Handshake: no ack for 5 cycles, then ack + new strobe together
    issue(3'b011, 1'b0, 32'h0, 32'hFFFF_FFF0);
    held = bif.con_out;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", bif.con_valid, 1'b1);
      check("hold_out", bif.con_out, held);
    end
    bif.con_ack = 1'b1;
    launch(3'b000, 1'b0, 32'h0, 32'd9);
    bif.con_ack = 1'b0;
    step();
    post_check(1'b0);
    ack();

    // con_in during EVAL is ignored
    launch(3'b010, 1'b0, 32'h0, 32'd3);
    bif.con_in = 1'b1; bif.bus = 32'h8000_0000; bif.ir_cond = 3'b111;
    step();
    bif.con_in = 1'b0;
    post_check(1'b1);
    ack();

    // Reset during EVAL: outputs clear at once, nothing counted
    launch(3'b110, 1'b0, 32'h0, 32'h0);
    clear_n = 1'b0;
    #1;
    check("arst_out", bif.con_out, 1'b0);
    check("arst_valid", bif.con_valid, 1'b0);
    check("arst_busy", bif.busy, 1'b0);
    check("arst_eval", bif.eval_count, 16'd0);
    check("arst_taken", bif.taken_count, 16'd0);
    m_eval = 0; m_taken = 0; s_eval = 0; s_taken = 0;
    step();
    clear_n = 1'b1;
    step();
    check("arst_novalid", bif.con_valid, 1'b0);

    // Saturation of the 2-bit counters
    for (int i = 0; i < 5; i++) begin
      issue(3'b110, 1'b0, 32'h0, $urandom);
      ack();
    end
    check("sat_eval", sif.eval_count, 2'd3);
    check("sat_taken", sif.taken_count, 2'd3);
    issue(3'b111, 1'b0, 32'h0, $urandom);
    check("sat_never", sif.taken_count, 2'd3);
    ack();

    // Randomized evaluations, sometimes back-to-back from HOLD
    for (int i = 0; i < 60; i++) begin
      rc = 3'($urandom_range(0, 7));
      rt = 1'($urandom_range(0, 1));
      ra = pick();
      rb = ($urandom_range(0, 4) == 0) ? ra : pick();
      issue(rc, rt, ra, rb);
      if ($urandom_range(0, 2) != 0) ack();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
